digit_seq_gen: RTL and testbench
================================

Name: digit_seq_gen

Overview:
Transmitter counterpart of the digit-sequence detector. On request it emits a one-cycle start pulse, then the 8-digit ID sequence 8,2,4,4,4,3,0,0 on digit_out, one digit per clock, repeated R times back-to-back. A detector can sample its outputs directly. Used as a stimulus source on the board and in the verification environment. A per-position corruption option supports negative testing of the detector.

Parameters:
N, 4, digit width in bits (must match detector's N from the shared package)
IDLE_DIGIT, 4'hF, value driven on digit_out when no digit is being sent (never appears in the sequence)

Ports:
clk  input  1  system clock, all logic on rising edge
asyn_n_rst  input  1  asynchronous active-low reset
go  input  1  transmit request, sampled only in IDLE
reps  input  4  repetition count, captured with go; 0 treated as 1
corrupt_en  input  1  captured with go; enables corruption of one position
corrupt_pos  input  3  captured with go; sequence index 0..7 to corrupt
abort  input  1  synchronous abort, highest priority after reset
busy  output  1  high from START through DONE inclusive
start_out  output  1  one-cycle pulse preceding the first digit (drives detector start)
digit_out  output  N  current digit, IDLE_DIGIT when not sending
digit_valid  output  1  high while digit_out carries a sequence digit
last_digit  output  1  high with index 7 of every repetition
done  output  1  one-cycle pulse after the final digit of the final repetition

Behaviour:
- Reset is asynchronous and active-low on asyn_n_rst. Under reset: state=IDLE, busy=0, start_out=0, digit_out=IDLE_DIGIT, digit_valid=0, last_digit=0, done=0, and all counters and captured fields are 0.
- All outputs are registered (Moore). Each is a function of the current state and counters only.
- States:
  - IDLE: go=1 at edge k. Capture reps (0->1), corrupt_en and corrupt_pos. Go to START.
  - START (cycle k+1): start_out=1, busy=1, digit_out=IDLE_DIGIT. Next state is SEND with idx=0, rep=1.
  - SEND (cycles k+2 onward):
    - digit_out=SEQ[idx], or SEQ[idx]^1 when corrupt_en and idx==corrupt_pos. Corruption applies in every repetition.
    - digit_valid=1; last_digit=(idx==7).
    - idx increments and wraps 7->0. At the wrap, rep increments.
    - When idx==7 and rep==reps_q, go to DONE.
  - DONE (cycle k+2+8*R): done=1, busy=1, digit_out=IDLE_DIGIT. Go to IDLE.
- Repetitions run back-to-back with no gap and no extra start pulse. A detector returns to its search-for-8 state after the final 0, so every repetition is detectable.
- go while not in IDLE is ignored. Inputs captured with go are frozen for the whole transaction.
- go is level-sampled: holding go high in IDLE re-triggers immediately after DONE (IDLE lasts 1 cycle).
- abort=1 at any edge in START, SEND or DONE: go to IDLE next cycle.
  - Outputs return to their idle values; no done pulse is produced.
  - abort in IDLE has no effect and takes priority over a simultaneous go.
- Reset asserted mid-transaction returns all outputs to their reset values immediately. No resume after reset.
- Counter widths: idx is 3 bits (wraps naturally); rep is 4 bits, compared with captured reps_q (range 1..15).

Decomposition:
- Shared package: N, the sequence constant SEQ (8 entries of N bits: 8,2,4,4,4,3,0,0), SEQ_LEN=8, and enum gen_state_t {IDLE, START, SEND, DONE}.
  - Keep these alongside the detector's state_d so both ends share one sequence definition.
- Single module; no sub-module needed. The SEQ lookup is a package constant indexed by idx.

Test Plan:
- Reset then go=1 at cycle 0, reps=1, corrupt_en=0:
  - start_out=1 at cycle 1; digit_out=8,2,4,4,4,3,0,0 at cycles 2..9; last_digit at cycle 9; done at cycle 10.
  - Connected detector asserts sequence_detected at cycle 9 only.
- reps=3: 24 digits at cycles 2..25 with no gaps.
  - last_digit at cycles 9, 17 and 25; done at cycle 26.
  - Detector fires at cycles 9, 17 and 25.
- reps=0: behaves exactly as reps=1 (done at cycle 10).
- corrupt_en=1, corrupt_pos=3, reps=2: digit_out=5 at cycles 5 and 13, all other digits nominal. Detector never fires; done at cycle 18.
- go pulsed again at cycle 4 of a reps=1 transaction: ignored. Exactly one done, at cycle 10, followed by IDLE.
- abort=1 at cycle 6: from cycle 7 busy=0, digit_out=4'hF, digit_valid=0, and no done.
  - Separately, asyn_n_rst low mid-SEND: outputs reach reset values without a clock edge.
  - A new go after either event starts cleanly with start_out one cycle later.

Source files
------------

// File: rtl/digit_seq_gen_pkg.sv
// rtl/digit_seq_gen_pkg.sv - shared digit width, ID sequence and generator state encoding
package digit_seq_gen_pkg;

  localparam int N       = 4;
  localparam int SEQ_LEN = 8;

  // ID sequence 8,2,4,4,4,3,0,0 with index 0 in the least significant digit
  localparam logic [SEQ_LEN*N-1:0] SEQ = {4'd0, 4'd0, 4'd3, 4'd4, 4'd4, 4'd4, 4'd2, 4'd8};

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    DONE
  } gen_state_t;

  // Nominal sequence digit at position i
  function automatic logic [N-1:0] seq_at(input logic [2:0] i);
    return SEQ[int'(i)*N +: N];
  endfunction

endpackage

// File: rtl/digit_seq_gen.sv
// rtl/digit_seq_gen.sv - emits start pulse then the 8-digit ID sequence R times, optional corruption
module digit_seq_gen
  import digit_seq_gen_pkg::*;
#(
  parameter int            N          = digit_seq_gen_pkg::N,
  parameter logic [N-1:0]  IDLE_DIGIT = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         asyn_n_rst,
  input  logic         go,
  input  logic [3:0]   reps,
  input  logic         corrupt_en,
  input  logic [2:0]   corrupt_pos,
  input  logic         abort,
  output logic         busy,
  output logic         start_out,
  output logic [N-1:0] digit_out,
  output logic         digit_valid,
  output logic         last_digit,
  output logic         done
);

  gen_state_t state;
  logic [2:0] idx;
  logic [3:0] rep;
  logic [3:0] reps_q;
  logic       corrupt_en_q;
  logic [2:0] corrupt_pos_q;
  logic [2:0] idx_nxt;

  assign idx_nxt = idx + 3'd1;

  // Digit for position i, with bit 0 flipped at the captured corruption position
  function automatic logic [N-1:0] gen_digit(input logic [2:0] i);
    logic [N-1:0] d;
    d = N'(seq_at(i));
    if (corrupt_en_q && (i == corrupt_pos_q)) d[0] = ~d[0];
    return d;
  endfunction

  // FSM with outputs registered alongside the state they belong to
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      state         <= IDLE;
      idx           <= '0;
      rep           <= '0;
      reps_q        <= '0;
      corrupt_en_q  <= 1'b0;
      corrupt_pos_q <= '0;
      busy          <= 1'b0;
      start_out     <= 1'b0;
      digit_out     <= IDLE_DIGIT;
      digit_valid   <= 1'b0;
      last_digit    <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy        <= 1'b0;
      start_out   <= 1'b0;
      digit_out   <= IDLE_DIGIT;
      digit_valid <= 1'b0;
      last_digit  <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        // abort also masks a go arriving in IDLE
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              reps_q        <= (reps == 4'd0) ? 4'd1 : reps;
              corrupt_en_q  <= corrupt_en;
              corrupt_pos_q <= corrupt_pos;
              state         <= START;
              busy          <= 1'b1;
              start_out     <= 1'b1;
            end
          end
          START: begin
            state       <= SEND;
            idx         <= 3'd0;
            rep         <= 4'd1;
            busy        <= 1'b1;
            digit_valid <= 1'b1;
            digit_out   <= gen_digit(3'd0);
          end
          SEND: begin
            busy <= 1'b1;
            if ((idx == 3'd7) && (rep == reps_q)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx         <= idx_nxt;
              if (idx == 3'd7) rep <= rep + 4'd1;
              digit_valid <= 1'b1;
              digit_out   <= gen_digit(idx_nxt);
              last_digit  <= (idx_nxt == 3'd7);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digit_seq_gen.sv
// tb/tb_digit_seq_gen.sv - scoreboard bench for digit_seq_gen
module tb_digit_seq_gen;

  logic       clk = 1'b0;
  logic       asyn_n_rst = 1'b0;
  logic       go = 1'b0;
  logic [3:0] reps = '0;
  logic       corrupt_en = 1'b0;
  logic [2:0] corrupt_pos = '0;
  logic       abort = 1'b0;
  logic       busy, start_out, digit_valid, last_digit, done;
  logic [3:0] digit_out;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       busy;
    logic       start;
    logic [3:0] digit;
    logic       valid;
    logic       last;
    logic       done;
  } obs_t;

  typedef struct {
    int reps;
    bit cen;
    int pos;
    int regos;
    int abort_cyc;
    int exp_done;
    int exp_det;
  } vec_t;

  int   tb_seq [8] = '{8, 2, 4, 4, 4, 3, 0, 0};
  obs_t sb_q [$];
  obs_t idle_obs;
  vec_t vecs [8];

  digit_seq_gen dut (
    .clk         (clk),
    .asyn_n_rst  (asyn_n_rst),
    .go          (go),
    .reps        (reps),
    .corrupt_en  (corrupt_en),
    .corrupt_pos (corrupt_pos),
    .abort       (abort),
    .busy        (busy),
    .start_out   (start_out),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .last_digit  (last_digit),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input bit b, input bit s, input int d, input bit v, input bit l, input bit dn);
    obs_t o;
    o.busy = b; o.start = s; o.digit = d[3:0]; o.valid = v; o.last = l; o.done = dn;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(busy, start_out, int'(digit_out), digit_valid, last_digit, done);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int   rr, t, done_at, det, d;
    obs_t a, e;
    int   win [8];
    bit   hit;
    rr = (v.reps == 0) ? 1 : v.reps;
    for (int k = 0; k < 8; k++) win[k] = 15;
    @(negedge clk);
    reps = v.reps[3:0]; corrupt_en = v.cen; corrupt_pos = v.pos[2:0]; go = 1'b1;
    sb_q.push_back(mk(1, 1, 15, 0, 0, 0));
    for (int r = 0; r < rr; r++)
      for (int i = 0; i < 8; i++) begin
        d = tb_seq[i] ^ ((v.cen && i == v.pos) ? 1 : 0);
        sb_q.push_back(mk(1, 0, d, 1, i == 7, 0));
      end
    sb_q.push_back(mk(1, 0, 15, 0, 0, 1));
    sb_q.push_back(idle_obs);
    if (v.abort_cyc > 0) begin
      while (sb_q.size() > v.abort_cyc) void'(sb_q.pop_back());
      repeat (3) sb_q.push_back(idle_obs);
    end
    t = 0; done_at = -1; det = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      t++;
      a = sample();
      e = sb_q.pop_front();
      chk($sformatf("trace reps=%0d cyc=%0d", v.reps, t), int'(a), int'(e));
      if (a.done && done_at < 0) done_at = t;
      if (a.valid) begin
        for (int k = 0; k < 7; k++) win[k] = win[k+1];
        win[7] = int'(a.digit);
        hit = 1'b1;
        for (int k = 0; k < 8; k++) if (win[k] != tb_seq[k]) hit = 1'b0;
        if (hit) det++;
      end else begin
        for (int k = 0; k < 8; k++) win[k] = 15;
      end
      go    = (t == v.regos);
      abort = (t == v.abort_cyc);
    end
    go = 1'b0; abort = 1'b0;
    chk($sformatf("done_cycle reps=%0d", v.reps), done_at, v.exp_done);
    chk($sformatf("detections reps=%0d", v.reps), det, v.exp_det);
  endtask

  initial begin
    obs_t a;
    idle_obs = mk(0, 0, 15, 0, 0, 0);
    //          reps cen pos regos abort done det
    vecs[0] = '{1,  0, 0, 0, 0, 10,  1};
    vecs[1] = '{3,  0, 0, 0, 0, 26,  3};
    vecs[2] = '{0,  0, 0, 0, 0, 10,  1};
    vecs[3] = '{2,  1, 3, 0, 0, 18,  0};
    vecs[4] = '{1,  0, 0, 4, 0, 10,  1};
    vecs[5] = '{1,  0, 0, 0, 6, -1,  0};
    vecs[6] = '{15, 1, 7, 0, 0, 122, 0};
    vecs[7] = '{1,  1, 0, 0, 0, 10,  0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(sample()), int'(idle_obs));
    asyn_n_rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", int'(sample()), int'(idle_obs));

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // abort in IDLE beats a simultaneous go
    @(negedge clk); go = 1'b1; abort = 1'b1;
    @(negedge clk); go = 1'b0; abort = 1'b0;
    chk("abort_beats_go", int'(sample()), int'(idle_obs));

    // asynchronous reset in the middle of SEND
    @(negedge clk); reps = 4'd2; corrupt_en = 1'b0; go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_send_valid", int'(digit_valid), 1);
    #2 asyn_n_rst = 1'b0;
    #1 chk("async_reset_outputs", int'(sample()), int'(idle_obs));
    @(negedge clk); asyn_n_rst = 1'b1;
    run(vecs[0]);

    // go held high re-triggers after a single IDLE cycle
    @(negedge clk); reps = 4'd1; corrupt_en = 1'b0; go = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      a = sample();
      if (t == 1)  chk("hold_go_start", int'(a.start), 1);
      if (t == 10) chk("hold_go_done", int'(a.done), 1);
      if (t == 11) chk("hold_go_idle", int'(a), int'(idle_obs));
      if (t == 12) chk("hold_go_restart", int'(a.start), 1);
    end
    go = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_from_start", int'(sample()), int'(idle_obs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
